// File: rtl/rnn_mem_responder_if.sv
// Bus bundle between the RNN core / host and the memory responder:
// core memory port, host load port, host dump port and status.
interface rnn_mem_responder_if #(
  parameter int DW = 20
);
  logic          mce;
  logic [2:0]    msel;
  logic [16:0]   maddr;
  logic [DW-1:0] mdata_w;
  logic [DW-1:0] mdata_r;

  logic          ld_valid;
  logic          ld_ready;
  logic [2:0]    ld_sel;
  logic [16:0]   ld_addr;
  logic [DW-1:0] ld_data;

  logic          dp_req;
  logic [16:0]   dp_len;
  logic          dp_valid;
  logic [16:0]   dp_addr;
  logic [DW-1:0] dp_data;

  logic [16:0]   wr_count;
  logic          err;

  modport master (
    output mce, msel, maddr, mdata_w,
    output ld_valid, ld_sel, ld_addr, ld_data,
    output dp_req, dp_len,
    input  mdata_r, ld_ready, dp_valid, dp_addr, dp_data, wr_count, err
  );

  modport slave (
    input  mce, msel, maddr, mdata_w,
    input  ld_valid, ld_sel, ld_addr, ld_data,
    input  dp_req, dp_len,
    output mdata_r, ld_ready, dp_valid, dp_addr, dp_data, wr_count, err
  );
endinterface

// File: rtl/rnn_mem_responder.sv
// Memory-side responder for the RNN core: six banks with a combinational core
// read port, a host load port and a host dump port for the output bank.
module rnn_mem_responder #(
  parameter int DW        = 20,
  parameter int OUT_DEPTH = 8192
) (
  input  logic             clk,
  input  logic             reset,
  rnn_mem_responder_if.slave bus
);

  localparam int         AW      = $clog2(OUT_DEPTH);
  localparam logic [17:0] OUT_LIM = 18'(OUT_DEPTH);

  localparam logic [2:0] SEL_WIH = 3'b000;
  localparam logic [2:0] SEL_BIH = 3'b001;
  localparam logic [2:0] SEL_WHH = 3'b010;
  localparam logic [2:0] SEL_BHH = 3'b011;
  localparam logic [2:0] SEL_HDR = 3'b100;
  localparam logic [2:0] SEL_OUT = 3'b101;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SERVE = 2'd2;
  localparam logic [1:0] DUMP  = 2'd3;

  logic [DW-1:0] w_ih    [2048];
  logic [DW-1:0] b_ih    [64];
  logic [DW-1:0] w_hh    [4096];
  logic [DW-1:0] b_hh    [64];
  logic [DW-1:0] header;
  logic [DW-1:0] out_mem [OUT_DEPTH];

  logic [1:0]  state;
  logic [16:0] dump_last;
  logic [16:0] dp_next;
  logic [17:0] len_clamp;

  logic ld_ready_int;
  logic ld_accept;
  logic ld_ok;
  logic core_wr;
  logic core_ok;

  function automatic logic in_range(input logic [2:0] sel, input logic [16:0] addr);
    case (sel)
      SEL_WIH: in_range = (addr < 17'd2048);
      SEL_BIH: in_range = (addr < 17'd64);
      SEL_WHH: in_range = (addr < 17'd4096);
      SEL_BHH: in_range = (addr < 17'd64);
      SEL_HDR: in_range = (addr == 17'd0);
      SEL_OUT: in_range = ({1'b0, addr} < OUT_LIM);
      default: in_range = 1'b0;
    endcase
  endfunction

  // Load handshake is withdrawn combinationally when the core claims the bus.
  assign ld_ready_int = (state == LOAD) && !bus.mce && !reset;
  assign bus.ld_ready = ld_ready_int;
  assign ld_accept    = bus.ld_valid && ld_ready_int;
  assign ld_ok        = ld_accept && in_range(bus.ld_sel, bus.ld_addr);

  assign core_wr = bus.mce && (bus.msel == SEL_OUT) && !reset;
  assign core_ok = core_wr && in_range(SEL_OUT, bus.maddr);

  assign dp_next   = bus.dp_addr + 17'd1;
  assign len_clamp = ({1'b0, bus.dp_len} > OUT_LIM) ? OUT_LIM : {1'b0, bus.dp_len};

  // Core read port; the output bank is write-only from the core side.
  always_comb begin
    bus.mdata_r = '0;
    if (bus.mce && in_range(bus.msel, bus.maddr)) begin
      case (bus.msel)
        SEL_WIH: bus.mdata_r = w_ih[bus.maddr[10:0]];
        SEL_BIH: bus.mdata_r = b_ih[bus.maddr[5:0]];
        SEL_WHH: bus.mdata_r = w_hh[bus.maddr[11:0]];
        SEL_BHH: bus.mdata_r = b_hh[bus.maddr[5:0]];
        SEL_HDR: bus.mdata_r = header;
        default: bus.mdata_r = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ld_ok) begin
      case (bus.ld_sel)
        SEL_WIH: w_ih[bus.ld_addr[10:0]]       <= bus.ld_data;
        SEL_BIH: b_ih[bus.ld_addr[5:0]]        <= bus.ld_data;
        SEL_WHH: w_hh[bus.ld_addr[11:0]]       <= bus.ld_data;
        SEL_BHH: b_hh[bus.ld_addr[5:0]]        <= bus.ld_data;
        SEL_HDR: header                        <= bus.ld_data;
        SEL_OUT: out_mem[bus.ld_addr[AW-1:0]]  <= bus.ld_data;
        default: ;
      endcase
    end
    if (core_ok) begin
      out_mem[bus.maddr[AW-1:0]] <= bus.mdata_w;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bus.dp_valid <= 1'b0;
      bus.dp_addr  <= '0;
      bus.dp_data  <= '0;
      bus.wr_count <= '0;
      bus.err      <= 1'b0;
      dump_last    <= '0;
    end else begin
      if ((core_wr && !core_ok) || (ld_accept && !ld_ok)) begin
        bus.err <= 1'b1;
      end
      if (core_ok && (bus.wr_count != '1)) begin
        bus.wr_count <= bus.wr_count + 17'd1;
      end

      case (state)
        IDLE: begin
          if (bus.mce) begin
            state <= SERVE;
          end else if (bus.dp_req && (bus.dp_len != '0)) begin
            state        <= DUMP;
            bus.dp_valid <= 1'b1;
            bus.dp_addr  <= '0;
            bus.dp_data  <= out_mem[AW'(0)];
            dump_last    <= 17'(len_clamp - 18'd1);
          end else if (bus.ld_valid) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (bus.mce) begin
            state <= SERVE;
          end else if (!bus.ld_valid) begin
            state <= IDLE;
          end
        end
        SERVE: begin
          if (!bus.mce) begin
            state <= IDLE;
          end
        end
        DUMP: begin
          if (bus.mce) begin
            state        <= SERVE;
            bus.dp_valid <= 1'b0;
          end else if (bus.dp_addr == dump_last) begin
            state        <= IDLE;
            bus.dp_valid <= 1'b0;
            bus.wr_count <= '0;
          end else begin
            bus.dp_addr <= dp_next;
            bus.dp_data <= out_mem[dp_next[AW-1:0]];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rnn_mem_responder.sv
// Directed self-checking bench for rnn_mem_responder: loads, core reads/writes,
// dumps with abort, reset and clamping.
module tb_rnn_mem_responder;

  localparam int DW        = 20;
  localparam int OUT_DEPTH = 8192;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rnn_mem_responder_if #(.DW(DW)) bus();

  rnn_mem_responder #(.DW(DW), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [19:0] model [OUT_DEPTH];
  bit          known [OUT_DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [2:0] sel, input logic [16:0] addr, input logic [19:0] data);
    bus.ld_valid = 1'b1;
    bus.ld_sel   = sel;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    tick();
    for (int k = 0; k < 8 && !bus.ld_ready; k++) tick();
    check("ld_ready_wait", 32'(bus.ld_ready), 32'd1);
    tick();
    bus.ld_valid = 1'b0;
    tick();
  endtask

  task automatic core_write(input int addr, input logic [19:0] data);
    bus.mce     = 1'b1;
    bus.msel    = 3'b101;
    bus.maddr   = 17'(addr);
    bus.mdata_w = data;
    tick();
    if (addr < OUT_DEPTH) begin
      model[addr] = data;
      known[addr] = 1'b1;
    end
  endtask

  task automatic end_core();
    bus.mce  = 1'b0;
    bus.msel = 3'b000;
    tick();
  endtask

  task automatic run_dump(input logic [16:0] len, input int abort_at, input int reset_at, output int n);
    int bad;
    int addr_err;
    bad      = 0;
    addr_err = 0;
    n        = 0;
    bus.dp_len = len;
    bus.dp_req = 1'b1;
    tick();
    bus.dp_req = 1'b0;
    for (int k = 0; k < 9000; k++) begin
      if (!bus.dp_valid) break;
      if (32'(bus.dp_addr) != n) addr_err++;
      if (n < OUT_DEPTH && known[n] && bus.dp_data !== model[n]) bad++;
      n++;
      if (n - 1 == abort_at) begin
        bus.msel = 3'b000;
        bus.mce  = 1'b1;
        tick();
        break;
      end
      if (n - 1 == reset_at) begin
        reset = 1'b1;
        tick();
        break;
      end
      tick();
    end
    check("dump_addr_seq", 32'(addr_err), 32'd0);
    check("dump_data", 32'(bad), 32'd0);
  endtask

  initial begin
    int n;
    int a;
    int acc;
    int bad;
    logic rdy;

    bus.mce = 1'b0; bus.msel = '0; bus.maddr = '0; bus.mdata_w = '0;
    bus.ld_valid = 1'b0; bus.ld_sel = '0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.dp_req = 1'b0; bus.dp_len = '0;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("rst_dp_valid", 32'(bus.dp_valid), 32'd0);
    check("rst_dp_addr", 32'(bus.dp_addr), 32'd0);
    check("rst_dp_data", 32'(bus.dp_data), 32'd0);
    check("rst_wr_count", 32'(bus.wr_count), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    tick();

    // Loads and same-cycle core reads
    load_word(3'b000, 17'd5, 20'h00123);
    load_word(3'b100, 17'd0, 20'd3);
    bus.mce = 1'b1; bus.msel = 3'b000; bus.maddr = 17'd5;
    #1 check("read_wih5", 32'(bus.mdata_r), 32'h00123);
    bus.msel = 3'b100; bus.maddr = 17'd0;
    #1 check("read_header", 32'(bus.mdata_r), 32'd3);
    bus.maddr = 17'd1;
    #1 check("read_header_oor", 32'(bus.mdata_r), 32'd0);
    bus.msel = 3'b110; bus.maddr = 17'd0;
    #1 check("read_sel110", 32'(bus.mdata_r), 32'd0);
    bus.msel = 3'b000; bus.maddr = 17'd2048;
    #1 check("read_wih_oor", 32'(bus.mdata_r), 32'd0);
    bus.mce = 1'b0; bus.maddr = 17'd5;
    #1 check("read_mce_low", 32'(bus.mdata_r), 32'd0);
    check("err_after_reads", 32'(bus.err), 32'd0);
    tick();

    // Core writes to out[64..127], then full dump
    for (int i = 0; i < 64; i++) core_write(64 + i, 20'(i));
    check("wr_count_64", 32'(bus.wr_count), 32'd64);
    end_core();
    run_dump(17'd128, -1, -1, n);
    check("dump128_len", 32'(n), 32'd128);
    check("dump128_wr_clear", 32'(bus.wr_count), 32'd0);

    // Load burst interrupted by mce
    load_word(3'b010, 17'd20, 20'h00777);
    a = 0; acc = 0;
    bus.ld_valid = 1'b1; bus.ld_sel = 3'b010;
    bus.ld_addr = 17'd0; bus.ld_data = 20'h00100;
    for (int c = 0; c < 12; c++) begin
      if (c == 4) begin
        bus.mce = 1'b1; bus.msel = 3'b000; bus.maddr = '0;
        bus.ld_addr = 17'd20; bus.ld_data = 20'h00BAD;
      end
      if (c == 6) begin
        bus.mce = 1'b0;
        bus.ld_addr = 17'(a); bus.ld_data = 20'(32'h100 + a);
      end
      #1;
      rdy = bus.ld_ready;
      if (c == 4) check("ld_ready_mce", 32'(rdy), 32'd0);
      if (c == 8) check("ld_ready_resume", 32'(rdy), 32'd1);
      tick();
      if (rdy) begin
        a++; acc++;
        bus.ld_addr = 17'(a); bus.ld_data = 20'(32'h100 + a);
      end
    end
    bus.ld_valid = 1'b0;
    tick(); tick();
    check("burst_beats", 32'(acc), 32'd7);
    bad = 0;
    bus.mce = 1'b1; bus.msel = 3'b010;
    for (int i = 0; i < 7; i++) begin
      bus.maddr = 17'(i);
      #1 if (bus.mdata_r !== 20'(32'h100 + i)) bad++;
    end
    check("burst_readback", 32'(bad), 32'd0);
    bus.maddr = 17'd20;
    #1 check("burst_no_mce_write", 32'(bus.mdata_r), 32'h00777);
    bus.mce = 1'b0;
    tick();

    // Out-of-range core write and load
    core_write(OUT_DEPTH - 1, 20'h04321);
    check("wr_last_err", 32'(bus.err), 32'd0);
    check("wr_last_count", 32'(bus.wr_count), 32'd1);
    core_write(OUT_DEPTH, 20'h55555);
    check("wr_oor_err", 32'(bus.err), 32'd1);
    check("wr_oor_count", 32'(bus.wr_count), 32'd1);
    end_core();
    load_word(3'b001, 17'd64, 20'h11111);
    check("ld_oor_err", 32'(bus.err), 32'd1);
    load_word(3'b001, 17'd63, 20'h0ABCD);
    bus.mce = 1'b1; bus.msel = 3'b001; bus.maddr = 17'd63;
    #1 check("bih63", 32'(bus.mdata_r), 32'h0ABCD);
    bus.maddr = 17'd64;
    #1 check("bih64_oor", 32'(bus.mdata_r), 32'd0);
    bus.mce = 1'b0; bus.msel = 3'b000;
    tick();

    // Priority and zero-length dump
    bus.dp_len = 17'd4; bus.dp_req = 1'b1; bus.mce = 1'b1;
    tick();
    bus.dp_req = 1'b0;
    check("mce_over_dp", 32'(bus.dp_valid), 32'd0);
    bus.mce = 1'b0;
    tick(); tick();
    check("dp_not_queued", 32'(bus.dp_valid), 32'd0);
    bus.dp_len = 17'd0; bus.dp_req = 1'b1;
    tick();
    bus.dp_req = 1'b0;
    check("dp_len0", 32'(bus.dp_valid), 32'd0);

    // Dump aborted by mce at word 40
    for (int i = 0; i < 100; i++) core_write(i, 20'(32'h200 + i));
    check("wr_count_101", 32'(bus.wr_count), 32'd101);
    end_core();
    run_dump(17'd100, 40, -1, n);
    check("abort_words", 32'(n), 32'd41);
    check("abort_valid_drop", 32'(bus.dp_valid), 32'd0);
    check("abort_keeps_count", 32'(bus.wr_count), 32'd101);
    repeat (3) tick();
    check("abort_no_wrap", 32'(bus.dp_valid), 32'd0);
    bus.dp_len = 17'd5; bus.dp_req = 1'b1;
    tick();
    bus.dp_req = 1'b0;
    check("serve_ignores_dp", 32'(bus.dp_valid), 32'd0);
    bus.mce = 1'b0;
    tick();

    // Reset mid-dump at word 10
    run_dump(17'd100, -1, 10, n);
    check("rstdump_words", 32'(n), 32'd11);
    check("rstdump_valid", 32'(bus.dp_valid), 32'd0);
    check("rstdump_wr_count", 32'(bus.wr_count), 32'd0);
    check("rstdump_err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    tick();
    check("rstdump_no_resume", 32'(bus.dp_valid), 32'd0);
    bus.mce = 1'b1; bus.msel = 3'b000; bus.maddr = 17'd5;
    #1 check("wih5_after_reset", 32'(bus.mdata_r), 32'h00123);
    bus.mce = 1'b0;
    tick();
    run_dump(17'd100, -1, -1, n);
    check("post_reset_dump_len", 32'(n), 32'd100);

    // Oversized dump length clamps to the bank depth
    run_dump(17'h1FFFF, -1, -1, n);
    check("clamp_len", 32'(n), 32'(OUT_DEPTH));
    check("clamp_wr_clear", 32'(bus.wr_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
